rr_arbiter_4: RTL and testbench

//   Round-robin arbiter that shares one downstream resource among 4 requesters.

---
 rtl/rr_arbiter_4.sv | 95 +++++++++
 tb/tb_rr_arbiter_4.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time per grant.
// Grant, encoded index and valid flag are all registered.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] hold_cnt;

  // First requester found scanning from start upward, wrapping mod 4.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  logic [2:0] arb_idle;
  logic [1:0] rel_ptr;
  logic [2:0] arb_rel;
  logic       keep;

  always_comb begin
    arb_idle = arbitrate(req, ptr);
    rel_ptr  = gnt_idx + 2'd1;
    arb_rel  = arbitrate(req, rel_ptr);
    keep     = req[gnt_idx] && (hold_cnt != HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_idle[2]) begin
            gnt       <= 4'b0001 << arb_idle[1:0];
            gnt_idx   <= arb_idle[1:0];
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (keep) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Release: the old holder becomes lowest priority, re-arbitrate with no bubble.
            ptr      <= rel_ptr;
            hold_cnt <= '0;
            if (arb_rel[2]) begin
              gnt       <= 4'b0001 << arb_rel[1:0];
              gnt_idx   <= arb_rel[1:0];
              gnt_valid <= 1'b1;
            end else begin
              gnt       <= 4'b0000;
              gnt_idx   <= 2'd0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: one instance with HOLD_MAX=4, one with HOLD_MAX=1.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.HOLD_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a)
  );

  rr_arbiter_4 #(.HOLD_MAX(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b)
  );

  typedef struct {
    int         id;
    logic [3:0] ga;
    logic [1:0] ia;
    logic       va;
    logic [3:0] gb;
    logic [1:0] ib;
    logic       vb;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  // Drive inputs on the falling edge; the response is expected after the next rising edge.
  task automatic step(input logic r, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] ga, input logic [1:0] ia,
                      input logic [3:0] gb, input logic [1:0] ib);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req_a = ra;
    req_b = rb;
    e.id = n_step;
    e.ga = ga; e.ia = ia; e.va = (ga != 4'b0000);
    e.gb = gb; e.ib = ib; e.vb = (gb != 4'b0000);
    q.push_back(e);
    n_step++;
  endtask

  // Monitor: pops one expectation per rising edge, sampled 2 time units later.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({gnt_a, idx_a, vld_a} !== {e.ga, e.ia, e.va}) begin
        n_fail++;
        $display("FAIL step%0d_holdmax4: got gnt=%b idx=%b vld=%b, want gnt=%b idx=%b vld=%b",
                 e.id, gnt_a, idx_a, vld_a, e.ga, e.ia, e.va);
      end
      n_cmp++;
      if ({gnt_b, idx_b, vld_b} !== {e.gb, e.ib, e.vb}) begin
        n_fail++;
        $display("FAIL step%0d_holdmax1: got gnt=%b idx=%b vld=%b, want gnt=%b idx=%b vld=%b",
                 e.id, gnt_b, idx_b, vld_b, e.gb, e.ib, e.vb);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req_a = 4'b0000;
    req_b = 4'b0000;

    // Reset held with all requests high: outputs stay idle.
    step(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 4'b0000, 2'd0);
    step(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // Single request, one-cycle latency, then drop.
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'b0000, 2'd0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // HOLD_MAX=1 pure rotation on the second instance.
    step(1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b0001, 2'd0);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b0010, 2'd1);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b0100, 2'd2);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b1000, 2'd3);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b0001, 2'd0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // HOLD_MAX=4 with two steady requesters: 4 cycles each, no gap (ptr is 3 here).
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2'd0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 4'b0000, 2'd0);
    step(1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2'd0);

    // Holder 0 drops with 1010 pending: same-edge handover to 1, then to 3.
    step(1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 4'b0000, 2'd0);
    step(1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 4'b0000, 2'd0);

    // Reset mid-grant, then pointer restarts at 0.
    step(1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0);
    step(1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2'd0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
